// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the IF stage and its IF/ID consumer.
package pipe_pkg;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } if_id_t;

  // Action taken by the fetch stage on the most recent clock edge.
  typedef enum logic [1:0] {
    FETCH_RESET = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_STALL = 2'd2,
    FETCH_FLUSH = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, flush and hold controls.
// Priority: rst > flush > hold > load.
import pipe_pkg::*;

module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  output if_id_t      q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q.valid    <= 1'b0;
      q.instr    <= NOP_INSTR;
      q.pc_plus4 <= 32'h0;
    end else if (flush) begin
      // pc_plus4 is deliberately kept; only the instruction slot is killed.
      q.valid <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (hold) begin
      q <= q;
    end else if (load) begin
      q.valid    <= 1'b1;
      q.instr    <= instr;
      q.pc_plus4 <= pc_plus4;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IMEM address and IF/ID register.
// Optional perf counters are built when IF_PERF_CNT_EN is defined.
import pipe_pkg::*;

module if_fetch_stage #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [DATA_W-1:0] redirect_pc_i,
  output logic [DATA_W-1:0] imem_addr_o,
  input  logic [DATA_W-1:0] imem_instr_i,
  output logic [DATA_W-1:0] pc_o,
  output logic              if_id_valid_o,
  output logic [DATA_W-1:0] if_id_instr_o,
  output logic [DATA_W-1:0] if_id_pc_plus4_o,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_flush_o,
`endif
  output fetch_state_t      fetch_state_o
);

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] pc_plus4;
  logic              do_redirect;
  logic              do_stall;
  logic              do_advance;
  if_id_t            if_id_q;

  // Redirect beats stall; a combined cycle is purely a flush.
  assign do_redirect = redirect_i;
  assign do_stall    = stall_i && !redirect_i;
  assign do_advance  = !stall_i && !redirect_i;

  assign pc_plus4 = pc_q + PC_STEP;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= PC_RESET;
    end else if (do_redirect) begin
      pc_q <= word_align(redirect_pc_i);
    end else if (do_advance) begin
      pc_q <= pc_plus4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_state_o <= FETCH_RESET;
    end else if (do_redirect) begin
      fetch_state_o <= FETCH_FLUSH;
    end else if (do_stall) begin
      fetch_state_o <= FETCH_STALL;
    end else begin
      fetch_state_o <= FETCH_RUN;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (do_advance),
    .flush    (do_redirect),
    .hold     (do_stall),
    .instr    (imem_instr_i),
    .pc_plus4 (pc_plus4),
    .q        (if_id_q)
  );

  assign imem_addr_o      = pc_q;
  assign pc_o             = pc_q;
  assign if_id_valid_o    = if_id_q.valid;
  assign if_id_instr_o    = if_id_q.valid ? if_id_q.instr : NOP_INSTR;
  assign if_id_pc_plus4_o = if_id_q.pc_plus4;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (do_advance)  fetch_cnt_q <= sat_inc(fetch_cnt_q);
      if (do_stall)    stall_cnt_q <= sat_inc(stall_cnt_q);
      if (do_redirect) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign perf_fetch_o = fetch_cnt_q;
  assign perf_stall_o = stall_cnt_q;
  assign perf_flush_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a spec-level model and literal checkpoints.
module tb_if_fetch_stage;
  import pipe_pkg::*;

  localparam logic [31:0] PC_RST = 32'h0000_0000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i, stall_i, redirect_i;
  logic [31:0]  redirect_pc_i, imem_addr_o, imem_instr_i, pc_o;
  logic         if_id_valid_o;
  logic [31:0]  if_id_instr_o, if_id_pc_plus4_o;
  fetch_state_t fetch_state_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0]  perf_fetch_o, perf_stall_o, perf_flush_o;
`endif

  if_fetch_stage #(.DATA_W(32), .PC_RESET(PC_RST)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_addr_o      (imem_addr_o),
    .imem_instr_i     (imem_instr_i),
    .pc_o             (pc_o),
    .if_id_valid_o    (if_id_valid_o),
    .if_id_instr_o    (if_id_instr_o),
    .if_id_pc_plus4_o (if_id_pc_plus4_o),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_o     (perf_fetch_o),
    .perf_stall_o     (perf_stall_o),
    .perf_flush_o     (perf_flush_o),
`endif
    .fetch_state_o    (fetch_state_o)
  );

  // Instruction memory contents: a distinct non-zero word per address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_instr_i = word_at(imem_addr_o);

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: what the stage must hold after each edge.
  logic [31:0] m_pc, m_instr, m_pp4, m_fetch, m_stall, m_flush;
  logic        m_valid;
  logic [1:0]  m_state;

  always @(posedge clk) begin
    if (rst_i) begin
      m_pc = PC_RST; m_valid = 1'b0; m_instr = 32'h0; m_pp4 = 32'h0;
      m_fetch = 0; m_stall = 0; m_flush = 0; m_state = 2'd0;
    end else if (redirect_i) begin
      m_pc = redirect_pc_i & 32'hFFFF_FFFC;
      m_valid = 1'b0; m_instr = 32'h0;
      if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
      m_state = 2'd3;
    end else if (stall_i) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      m_state = 2'd2;
    end else begin
      m_valid = 1'b1; m_instr = word_at(m_pc); m_pp4 = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 1;
      m_state = 2'd1;
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc_o, m_pc);
      check("imem_addr", imem_addr_o, m_pc);
      check("valid", {31'b0, if_id_valid_o}, {31'b0, m_valid});
      check("instr", if_id_instr_o, m_instr);
      check("pc_plus4", if_id_pc_plus4_o, m_pp4);
      check("state", {30'b0, fetch_state_o}, {30'b0, m_state});
`ifdef IF_PERF_CNT_EN
      check("perf_fetch", perf_fetch_o, m_fetch);
      check("perf_stall", perf_stall_o, m_stall);
      check("perf_flush", perf_flush_o, m_flush);
`endif
    end
  end

  // driver: apply inputs, take one edge, return 2 time units after it
  task automatic cyc(input logic r, input logic s, input logic rd, input logic [31:0] t);
    rst_i = r; stall_i = s; redirect_i = rd; redirect_pc_i = t;
    @(posedge clk);
    #2;
  endtask

`ifdef IF_PERF_CNT_EN
  logic [31:0] f0, s0;
`endif

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    chk_en = 1'b1;
    check("rst_pc", pc_o, 32'h0);
    check("rst_valid", {31'b0, if_id_valid_o}, 32'h0);
    check("rst_instr", if_id_instr_o, 32'h0);
    check("rst_pp4", if_id_pc_plus4_o, 32'h0);

    // free run of four fetches
    exp_q.push_back(32'hFFFF_0000);
    exp_q.push_back(32'hFFFB_0004);
    exp_q.push_back(32'hFFF7_0008);
    exp_q.push_back(32'hFFF3_000C);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, 32'h0);
      check("run_instr", if_id_instr_o, exp_q.pop_front());
      check("run_pp4", if_id_pc_plus4_o, 32'((k + 1) * 4));
    end
    check("run_pc", pc_o, 32'd16);
`ifdef IF_PERF_CNT_EN
    check("run_perf_fetch", perf_fetch_o, 32'd4);
`endif

    // two-cycle stall at PC=8
    cyc(1, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 0, 32'h0);
      check("stall_pc", pc_o, 32'd8);
      check("stall_instr", if_id_instr_o, 32'hFFFB_0004);
      check("stall_pp4", if_id_pc_plus4_o, 32'd8);
    end
    cyc(0, 0, 0, 32'h0);
    check("post_stall_instr", if_id_instr_o, 32'hFFF7_0008);
    check("post_stall_pp4", if_id_pc_plus4_o, 32'd12);
    check("post_stall_pc", pc_o, 32'd12);

    // redirect to 0x40 at PC=12
    cyc(0, 0, 1, 32'h40);
    check("redir_pc", pc_o, 32'h40);
    check("redir_valid", {31'b0, if_id_valid_o}, 32'h0);
    check("redir_instr", if_id_instr_o, 32'h0);
    check("redir_pp4_kept", if_id_pc_plus4_o, 32'd12);
    cyc(0, 0, 0, 32'h0);
    check("target_instr", if_id_instr_o, 32'hFFBF_0040);
    check("target_pp4", if_id_pc_plus4_o, 32'h44);

    // redirect and stall together, unaligned target
`ifdef IF_PERF_CNT_EN
    f0 = m_flush; s0 = m_stall;
`endif
    cyc(0, 1, 1, 32'h21);
    check("both_pc", pc_o, 32'h20);
    check("both_valid", {31'b0, if_id_valid_o}, 32'h0);
    check("both_state", {30'b0, fetch_state_o}, {30'b0, FETCH_FLUSH});
`ifdef IF_PERF_CNT_EN
    check("both_perf_flush", perf_flush_o, f0 + 32'd1);
    check("both_perf_stall", perf_stall_o, s0);
`endif

    // wrap at the top of the address space
    cyc(0, 0, 1, 32'hFFFF_FFFC);
    check("wrap_redir_pc", pc_o, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 32'h0);
    check("wrap_pc", pc_o, 32'h0);
    check("wrap_pp4", if_id_pc_plus4_o, 32'h0);
    check("wrap_instr", if_id_instr_o, 32'h0003_FFFC);

    // reset during a redirect cycle
    cyc(0, 1, 0, 32'h0);
    cyc(1, 0, 1, 32'h80);
    check("rst_redir_pc", pc_o, PC_RST);
    check("rst_redir_valid", {31'b0, if_id_valid_o}, 32'h0);
    check("rst_redir_pp4", if_id_pc_plus4_o, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("rst_perf_fetch", perf_fetch_o, 32'h0);
    check("rst_perf_stall", perf_stall_o, 32'h0);
    check("rst_perf_flush", perf_flush_o, 32'h0);
`endif
    cyc(0, 0, 0, 32'h0);
    check("after_rst_instr", if_id_instr_o, 32'hFFFF_0000);
    check("after_rst_pc", pc_o, 32'd4);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the pipelined MIPS CPU. Holds the PC, drives the instruction-memory address, and registers the fetched instruction and PC+4 into the IF/ID pipeline register. It sits directly upstream of the ID stage, which resolves `beq` and drives the redirect inputs of this block. The hazard unit drives the stall input.

## Interface
Parameters:
- `PC_RESET`, default `32'h0000_0000`: PC value after reset. Must be word-aligned.
- `DATA_W`, default 32: instruction and PC width.

Ports:
- `clk_i`, in, 1: single clock. All state updates on the rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `stall_i`, in, 1: load-use stall from the hazard unit. Holds the PC and IF/ID.
- `redirect_i`, in, 1: branch taken, resolved in ID.
- `redirect_pc_i`, in, 32: branch target.
- `imem_addr_o`, out, 32: instruction-memory address, equal to the current PC (combinational).
- `imem_instr_i`, in, 32: instruction read combinationally at `imem_addr_o`.
- `pc_o`, out, 32: current PC.
- `if_id_valid_o`, out, 1: IF/ID holds a real instruction.
- `if_id_instr_o`, out, 32: IF/ID instruction. Reads as NOP when not valid.
- `if_id_pc_plus4_o`, out, 32: IF/ID PC+4, the not-taken successor used by ID.
- `perf_fetch_o`, `perf_stall_o`, `perf_flush_o`, out, 32 each: present only with `IF_PERF_CNT_EN`.

## Operation
- The per-edge update priority is: reset > redirect > stall > advance.
- **Reset:**
  - PC ← `PC_RESET`.
  - `if_id_valid_o`=0, `if_id_instr_o`=32'h0, `if_id_pc_plus4_o`=0.
  - All perf counters ← 0.
- **Redirect:**
  - PC ← {`redirect_pc_i`[31:2], 2'b00}. Low bits are forced to 0.
  - IF/ID is flushed: valid=0, instr=NOP, pc_plus4 unchanged.
  - The instruction fetched this cycle is discarded.
- **Stall (without redirect):**
  - PC and all IF/ID fields hold.
  - `imem_addr_o` is unchanged, so the same instruction is refetched next cycle.
- **Advance:**
  - PC ← PC+4.
  - IF/ID ← {valid=1, `imem_instr_i`, PC+4}.
- **Simultaneous redirect and stall:** redirect wins. It is counted only as a flush.
- **Arithmetic:** PC+4 is 32-bit modulo. 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- **Reset mid-operation:** reset overrides a pending redirect or stall in the same cycle. Nothing in flight is kept.
- The state is conceptually RUN, STALL or FLUSH, selected each cycle by the inputs. There is no multi-cycle FSM memory beyond the PC and IF/ID registers.

## Timing
- `imem_addr_o` and `pc_o` change only on clock edges, and are combinational copies of the PC register.
- Fetch latency is 1 cycle: the instruction at PC=A appears in `if_id_instr_o`, with `if_id_pc_plus4_o`=A+4, one edge after A is presented.
- Branch penalty is 1 bubble: with a redirect at edge N, IF/ID is invalid after N and the target instruction is in IF/ID after N+1.
- Stall of K cycles: IF/ID holds its value for exactly K edges, then advances on the first edge where `stall_i`=0.

## Configuration
- **With `IF_PERF_CNT_EN` defined**, three 32-bit counters are present:
  - `perf_fetch_o` counts edges that load a valid instruction into IF/ID.
  - `perf_stall_o` counts stall-without-redirect edges.
  - `perf_flush_o` counts redirect edges.
  - All three saturate at 32'hFFFF_FFFF and clear on reset.
- **Without `IF_PERF_CNT_EN`**, the counter ports and logic are absent. All other behaviour is identical.

## Structure
- Package `pipe_pkg` holds:
  - `NOP_INSTR` (32'h0) and `PC_STEP` (4).
  - Typedef `if_id_t` {valid, instr, pc_plus4}, shared with the ID stage.
- Sub-module `if_id_reg` implements the IF/ID register with `load`, `flush` and `hold` controls. The PC register and perf counters live in the top module.

## Test plan
- Reset with `PC_RESET`=0, then 4 free cycles: IMEM words 0..3 appear in IF/ID with pc_plus4 = 4, 8, 12, 16; `pc_o`=16.
- Stall held for 2 cycles at PC=8: `pc_o` stays 8 and IF/ID keeps the word 1 / pc_plus4=8 for 2 edges, then the word at 8 loads.
- Redirect with target 32'h40 at PC=12: next edge gives `pc_o`=32'h40 and `if_id_valid_o`=0, and the edge after loads the word at 0x40 with pc_plus4=0x44.
- Redirect and stall asserted together, target 32'h21: `pc_o`=32'h20, IF/ID flushed; with `IF_PERF_CNT_EN`, `perf_flush_o`+1 and `perf_stall_o` unchanged.
- Redirect to 32'hFFFF_FFFC, then advance: `pc_o` wraps to 0 and `if_id_pc_plus4_o`=0.
- Reset asserted during a redirect cycle: `pc_o`=`PC_RESET`, IF/ID invalid, all counters 0.
